div_unit: RTL and testbench

Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage beside the single-cycle ALU and is fed by the same forwarded operand muxes (inA = rs1, inB = rs2). Its registered result is merged into the EX result mux. While it is busy, the hazard unit uses `busy` to stall IF/ID/EX.

---
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
//
// Restoring radix-2 divider that produces one quotient bit per cycle.
// Divide-by-zero and signed overflow finish in the sampling cycle. Every
// other operation takes 32 DIVIDE cycles plus one FIX cycle.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous reset, active low
//   start  - request, sampled only while idle
//   op     - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   inA    - dividend (rs1)
//   inB    - divisor (rs2)
//   flush  - synchronous abort; returns to idle without a result
//   busy   - high while a division is in flight (registered)
//   valid  - one-cycle pulse when out has been updated
//   out    - registered result, held until the next result
module div_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         flush,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_FIX    = 2'd2;

  localparam int              CW   = $clog2(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);
  localparam logic [N-1:0]    MIN_NEG = {1'b1, {(N-1){1'b0}}};

  logic [1:0]   state;
  logic [CW-1:0] cnt;
  logic [N-1:0] rem;
  logic [N-1:0] quo;
  logic [N-1:0] divisor;
  logic         op_rem;
  logic         neg_q;
  logic         neg_r;

  logic         is_signed;
  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] a_abs;
  logic [N-1:0] b_abs;
  logic         overflow;
  logic [N:0]   shifted;
  logic [N:0]   trial;
  logic [N-1:0] result;

  assign busy = (state != S_IDLE);

  // Operand preparation while idle. The remainder stays below the divisor,
  // so N bits hold it between iterations. Only the shifted value needs the
  // extra bit so that trial's top bit is a valid sign.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & inA[N-1];
    b_neg     = is_signed & inB[N-1];
    a_abs     = a_neg ? (~inA + 1'b1) : inA;
    b_abs     = b_neg ? (~inB + 1'b1) : inB;
    overflow  = is_signed && (inA == MIN_NEG) && (inB == '1);
    shifted   = {rem, quo[N-1]};
    trial     = shifted - {1'b0, divisor};
    if (op_rem)
      result = neg_r ? (~rem + 1'b1) : rem;
    else
      result = neg_q ? (~quo + 1'b1) : quo;
  end

  // Control and datapath. flush wins over everything, including a start in
  // the same cycle and the result of the FIX cycle. valid defaults low every
  // cycle, so it pulses only on an edge that loads out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      op_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      valid   <= 1'b0;
      out     <= '0;
    end else begin
      valid <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (inB == '0) begin
                out   <= op[1] ? inA : '1;
                valid <= 1'b1;
              end else if (overflow) begin
                out   <= op[1] ? '0 : MIN_NEG;
                valid <= 1'b1;
              end else begin
                op_rem  <= op[1];
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= a_neg;
                quo     <= a_abs;
                divisor <= b_abs;
                rem     <= '0;
                cnt     <= '0;
                state   <= S_DIVIDE;
              end
            end
          end
          S_DIVIDE: begin
            // quo doubles as the dividend shift register; quotient bits
            // enter at the bottom as dividend bits leave at the top.
            if (!trial[N]) begin
              rem <= trial[N-1:0];
              quo <= {quo[N-2:0], 1'b1};
            end else begin
              rem <= shifted[N-1:0];
              quo <= {quo[N-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
              state <= S_FIX;
          end
          S_FIX: begin
            out   <= result;
            valid <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit.
// Directed cases followed by randomized operations checked against an
// arithmetic reference model.
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  opSig;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] out;

  int errors;
  int checks;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  div_unit #(.N(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op(opSig),
    .inA(inA),
    .inB(inB),
    .flush(flush),
    .busy(busy),
    .valid(valid),
    .out(out)
  );

  // Free-running clock, 10 time units per period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference result from RISC-V arithmetic rules using wide integers
  function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    case (o)
      DIV:     r = sa / sb;
      DIVU:    r = ua / ub;
      REM:     r = sa % sb;
      default: r = ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic bit isSpecial(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive a request at the negedge, cross the sampling edge E0, then
  // scramble the operand inputs to show they are not used after latching
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1;
    opSig = o;
    inA   = a;
    inB   = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    opSig = 2'($urandom);
    inA   = $urandom;
    inB   = $urandom;
  endtask

  // Wait for the result of a normal-path operation; c0 is the edge index
  // already reached since E0
  task automatic waitResult(input string tag, input logic [31:0] expected, input int c0);
    int c;
    bit busyOk;
    c = c0;
    busyOk = 1'b1;
    while (valid !== 1'b1 && c < 40) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      @(posedge clock);
      #1;
      c++;
    end
    checkOutput({tag, " latency"}, 32'(c), 32'd33);
    checkOutput({tag, " busy during run"}, 32'(busyOk), 32'd1);
    checkOutput({tag, " valid"}, 32'(valid), 32'd1);
    checkOutput({tag, " out"}, out, expected);
    checkOutput({tag, " busy at result"}, 32'(busy), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expected;
    expected = refResult(o, a, b);
    applyStimulus(o, a, b);
    if (isSpecial(o, a, b)) begin
      checkOutput({tag, " special valid"}, 32'(valid), 32'd1);
      checkOutput({tag, " special out"}, out, expected);
      checkOutput({tag, " special busy"}, 32'(busy), 32'd0);
    end else begin
      waitResult(tag, expected, 0);
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    bit sawValid;
    errors = 0;
    checks = 0;
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    opSig = 2'b00;
    inA   = 32'd0;
    inB   = 32'd0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset valid", 32'(valid), 32'd0);
    checkOutput("reset out", out, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Unsigned and signed division, REMU issued back-to-back with DIVU
    runOp("DIVU 100/7", DIVU, 32'd100, 32'd7);
    runOp("REMU 100/7", REMU, 32'd100, 32'd7);
    runOp("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2);
    runOp("REM -7/2", REM, 32'hFFFF_FFF9, 32'd2);
    runOp("REM 7/-2", REM, 32'd7, 32'hFFFF_FFFE);
    @(posedge clock);
    #1;
    checkOutput("valid one cycle", 32'(valid), 32'd0);

    // Special cases
    runOp("DIV 5/0", DIV, 32'd5, 32'd0);
    runOp("REMU 5/0", REMU, 32'd5, 32'd0);
    runOp("DIV ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("REM ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF);
    @(posedge clock);
    #1;
    checkOutput("special valid one cycle", 32'(valid), 32'd0);

    // Start during DIVIDE is ignored
    applyStimulus(DIVU, 32'd1000, 32'd3);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1;
    opSig = DIVU;
    inA   = 32'd50;
    inB   = 32'd0;
    @(posedge clock);
    #1;
    start = 1'b0;
    waitResult("ignored start", 32'd333, 5);

    // Back-to-back start in the valid cycle
    runOp("back-to-back 9/3", DIVU, 32'd9, 32'd3);

    // Flush mid-division, then a fresh start right after
    applyStimulus(DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    checkOutput("flush busy", 32'(busy), 32'd0);
    checkOutput("flush valid", 32'(valid), 32'd0);
    checkOutput("flush out held", out, 32'd3);
    runOp("after flush 77/5", DIVU, 32'd77, 32'd5);

    // Flush in the FIX cycle suppresses the result
    held = out;
    applyStimulus(DIVU, 32'd50, 32'd6);
    repeat (32) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    checkOutput("fix flush valid", 32'(valid), 32'd0);
    checkOutput("fix flush out", out, held);
    checkOutput("fix flush busy", 32'(busy), 32'd0);

    // Flush has priority over a coincident start
    @(negedge clock);
    start = 1'b1;
    flush = 1'b1;
    opSig = DIV;
    inA   = 32'd5;
    inB   = 32'd0;
    @(posedge clock);
    #1;
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush vs start valid", 32'(valid), 32'd0);
    checkOutput("flush vs start out", out, held);

    // Asynchronous reset in the middle of a division
    applyStimulus(DIVU, 32'd12345, 32'd11);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset valid", 32'(valid), 32'd0);
    checkOutput("mid reset out", out, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("no valid after reset", 32'(sawValid), 32'd0);

    // Randomized operations, mixing in the corner cases
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(0, 20)) - 32'd10; end
        3: begin a = $urandom; b = 32'($urandom_range(1, 15)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      runOp($sformatf("rand%0d op=%0d a=%h b=%h", i, o, a, b), o, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
